// File: rtl/rf_pkg.sv
// Shared widths, payload types and grant encoding for the register-file write path.
package rf_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 16;
    localparam int unsigned SEL_W  = 4;

    typedef logic [SEL_W-1:0]  rf_sel_t;
    typedef logic [DATA_W-1:0] rf_data_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

endpackage : rf_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0]=A, req[1]=B; a tie goes to whoever did not win last.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    grant_t last_q;
    grant_t last_d;

    // Last-grant register; reset to B so A wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GRANT_B;
        end else begin
            last_q <= last_d;
        end
    end

    // Grant decode and pointer update; depends only on req and last_q.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_q == GRANT_B) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (gnt[0]) begin
            last_d = GRANT_A;
        end else if (gnt[1]) begin
            last_d = GRANT_B;
        end
    end

endmodule : rr_arb2

// File: rtl/rf_write_scheduler.sv
// Shares the register-file write port between two writeback requesters and tracks per-register busy state.
module rf_write_scheduler
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     a_valid,
    input  rf_sel_t  a_sel,
    input  rf_data_t a_data,
    output logic     a_ready,
    input  logic     b_valid,
    input  rf_sel_t  b_sel,
    input  rf_data_t b_data,
    output logic     b_ready,
    input  logic     rsv_valid,
    input  rf_sel_t  rsv_sel,
    input  rf_sel_t  chk_sel1,
    input  rf_sel_t  chk_sel2,
    output logic     chk_busy1,
    output logic     chk_busy2,
    output logic     rf_we,
    output rf_sel_t  rf_sel_in,
    output rf_data_t rf_in
);

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    assign req = {b_valid, a_valid};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];

    // Output register: a handshake loads the write; sel/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_sel_in <= '0;
            rf_in     <= '0;
        end else begin
            rf_we <= |gnt;
            if (gnt[0]) begin
                rf_sel_in <= a_sel;
                rf_in     <= a_data;
            end else if (gnt[1]) begin
                rf_sel_in <= b_sel;
                rf_in     <= b_data;
            end
        end
    end

    // Scoreboard next state: clear on regfile write, then set so a new reservation wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we) begin
            busy_d[rf_sel_in] = 1'b0;
        end
        if (rsv_valid) begin
            busy_d[rsv_sel] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign chk_busy1 = busy_q[chk_sel1];
    assign chk_busy2 = busy_q[chk_sel2];

endmodule : rf_write_scheduler

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Owns the single write port of the 16x16 register file (we, sel_in, in).
- Shares that port between two writeback requesters: A (ALU result) and B (load/external result), using round-robin arbitration with valid/ready handshakes.
- Keeps a per-register busy scoreboard. Issue logic uses it to detect read-after-write hazards on the two read selects before reading o1/o2.

Parameters:
- DATA_W, 16, register data width.
- NREGS, 16, number of registers.
- SEL_W, 4, register select width (log2 NREGS).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has a write pending.
- a_sel  in  SEL_W  requester A destination register.
- a_data  in  DATA_W  requester A write data.
- a_ready  out  1  requester A granted this cycle.
- b_valid  in  1  requester B has a write pending.
- b_sel  in  SEL_W  requester B destination register.
- b_data  in  DATA_W  requester B write data.
- b_ready  out  1  requester B granted this cycle.
- rsv_valid  in  1  reserve a destination register (instruction issued).
- rsv_sel  in  SEL_W  register to mark busy.
- chk_sel1  in  SEL_W  hazard check select, read port 1.
- chk_sel2  in  SEL_W  hazard check select, read port 2.
- chk_busy1  out  1  busy[chk_sel1].
- chk_busy2  out  1  busy[chk_sel2].
- rf_we  out  1  to register file we.
- rf_sel_in  out  SEL_W  to register file sel_in.
- rf_in  out  DATA_W  to register file in.

Behaviour:
- Reset (async, rst=1):
  - rf_we=0, rf_sel_in=0, rf_in=0, busy[*]=0.
  - Round-robin pointer last_grant=B, so A wins the first tie.
  - An accepted-but-unwritten transfer is dropped; rf_we falls immediately, not at the next edge.
- Arbitration (combinational):
  - Only A valid -> a_ready=1.
  - Only B valid -> b_ready=1.
  - Both valid -> grant the requester not in last_grant.
  - Neither valid -> both ready=0.
  - a_ready and b_ready are never both 1.
  - ready never depends on ready (no loops); it does not depend on data.
- Transfer: a handshake (valid & ready) at edge N does the following at that edge:
  - Loads rf_we=1, rf_sel_in=sel, rf_in=data.
  - Updates last_grant to the granted requester.
- The register file captures the write at edge N+1; the new value is readable on o1/o2 after N+1. Total latency: accept edge to regfile write = 1 cycle.
- No handshake at edge N -> rf_we=0 after N. rf_sel_in and rf_in hold their last values.
- Back-to-back: one write per cycle sustained. With both requesters continuously valid, grants alternate A,B,A,B...
- Requesters hold valid/sel/data stable until ready; the block adds no buffering beyond the output register.
- Scoreboard:
  - rsv_valid at edge -> busy[rsv_sel]=1.
  - rf_we=1 at edge -> busy[rf_sel_in]=0. The clear coincides with the regfile write edge.
  - Set and clear of the same register at the same edge: set wins (a newer reservation is outstanding).
  - Set and clear of different registers at the same edge: both take effect.
- chk_busy1/2 are combinational reads of the busy register and reflect edge updates immediately after the edge.
- Writes to a register not marked busy are legal and perform normally; the clear is a no-op.
- Register 0 is not special; it is written like any other.
- Selects wrap only within SEL_W; no out-of-range handling is needed when NREGS = 2^SEL_W.

Decomposition:
- Package rf_pkg:
  - DATA_W=16, NREGS=16, SEL_W=4.
  - typedef rf_sel_t (SEL_W bits), rf_data_t (DATA_W bits).
  - typedef enum grant_t {GRANT_A, GRANT_B}.
- Sub-module rr_arb2:
  - Two-way round-robin arbiter: req[1:0] in, gnt[1:0] out, last-grant state, clk/rst.
  - Scoreboard and output register stay in rf_write_scheduler.

Test Plan:
- Reset then A-only: a_valid=1, a_sel=3, a_data=16'h00A5 for one cycle -> a_ready=1, b_ready=0; rf_we=1 with rf_sel_in=3 and rf_in=00A5 in the next cycle; regfile o1 reads 00A5 with sel_o1=3 after the following edge.
- Tie: A (sel 1, 16'h0011) and B (sel 2, 16'h0022) both held valid -> A granted first cycle, B second; rf writes r1=0011 then r2=0022 on consecutive edges; no cycle with both ready.
- Fairness: both valid for 6 cycles with new data each grant -> grants A,B,A,B,A,B; 6 consecutive rf_we=1 cycles.
- Scoreboard: rsv_valid sel 5 -> chk_sel1=5 gives chk_busy1=1; B writes sel 5 -> chk_busy1 stays 1 through the accept edge, drops to 0 after the rf write edge.
- Set/clear collision: r7 busy; at the edge where rf_we=1 with rf_sel_in=7, also rsv_valid with rsv_sel=7 -> busy[7] remains 1. Same test with rsv_sel=8 -> busy[7]=0, busy[8]=1.
- Reset mid-operation: accept A (sel 4) then assert rst before the next edge -> rf_we drops to 0 immediately, r4 unchanged, all chk_busy=0; after release, the first tie is granted to A.
